cordic_vector: RTL
==================

CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 SHALL have parameter ITER, default 16, meaning the number of micro-rotations, legal range 1..16.
REQ-002 SHALL have parameter W_IN, default 21, meaning input width: signed Q1.20.
REQ-003 SHALL have parameter W_OUT, default 23, meaning output width: signed Q3.20.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-005 SHALL have port clock, input, 1 bit: the sole clock, rising-edge active.
REQ-006 SHALL have port aclr_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port clk_en, input, 1 bit: when low, all state holds.
REQ-008 SHALL have port start, input, 1 bit: loads operands and begins a conversion.
REQ-009 SHALL have port x_in, input, W_IN bits: signed x operand.
REQ-010 SHALL have port y_in, input, W_IN bits: signed y operand.
REQ-011 SHALL have port angle, output, W_OUT bits: atan2(y,x) in radians.
REQ-012 SHALL have port magnitude, output, W_OUT bits: vector length.
REQ-013 SHALL have port done, output, 1 bit: results are valid.

Function
REQ-014 SHALL implement the states IDLE, PREROT, ITER and DONE, plus GAIN when CORDIC_VEC_GAIN_EN is defined.
REQ-015 SHALL sample start only when clk_en=1; start in any state (including ITER and GAIN) aborts the current work, captures x_in and y_in, and enters PREROT.
REQ-016 SHALL sign-extend operands to W_OUT bits in PREROT and apply quadrant pre-rotation:
- x>=0: no change, z=0.
- x<0 and y>=0: (x,y)<=(y,-x), z=+pi/2 (0x1921FB).
- x<0 and y<0: (x,y)<=(-y,x), z=-pi/2.
REQ-017 SHALL perform one micro-rotation per enabled cycle in ITER at index i=0..ITER-1:
- y>=0: x+=y>>>i, y-=x>>>i, z+=atan(2^-i).
- y<0: x-=y>>>i, y+=x>>>i, z-=atan(2^-i).
- Shifts are arithmetic; all updates use the pre-update x, y and z.
REQ-018 SHALL leave ITER after index ITER-1, entering GAIN when the macro is defined and DONE otherwise.
REQ-019 SHALL drive angle=z and magnitude=x; both are held stable while in DONE.
REQ-020 SHALL assert done only in DONE and hold it until the next accepted start.
REQ-021 SHALL have a latency, counted from the start-sampling edge to done high, of 1+ITER edges without the macro and 2+ITER edges with it (16-iteration figures in REQ-031).
REQ-022 SHALL produce angle 0 and magnitude 0 for x=y=0.
REQ-023 SHALL produce angle near +pi for the input x=-1.0, y=0; this is not an error case.
REQ-024 SHALL produce no internal overflow for inputs within ±1.0, because the maximum raw magnitude is 2.33, which fits Q3.20.
REQ-025 SHALL ignore start while clk_en=0, and SHALL hold the index counter and state while clk_en=0.

Reset
REQ-026 SHALL, on aclr_n low, immediately and asynchronously force state=IDLE, the index counter to 0, x=y=z=0 and done=0, so that angle and magnitude read 0.
REQ-027 SHALL abort any conversion in progress when reset is asserted; no done pulse follows.
REQ-028 SHALL wait after reset release for a new start.

Configuration
REQ-029 SHALL, with CORDIC_VEC_GAIN_EN defined:
- Add the single-cycle state GAIN.
- In GAIN, set magnitude = (x*K)>>>20, truncated to W_OUT bits, where K=0x09B74E (0.60725).
- The result is the true length.
REQ-030 SHALL, with CORDIC_VEC_GAIN_EN undefined:
- Omit GAIN and contain no multiplier.
- Output the raw magnitude, which is 1.64676 times the true length.

Structure
REQ-031 SHALL take these shared items from package cordic_pkg:
- The atan LUT, 16 entries matching the rotation block's 0x0C90FE..0x000020 (index0 = 0x0C90FE).
- K = 0x09B74E.
- PI_2 = 0x1921FB and PI = 0x3243F6.
- The state enum.
- Latency constants: 17 without CORDIC_VEC_GAIN_EN, 18 with it.
REQ-032 SHALL place one micro-rotation in combinational sub-module cordic_vec_step, with inputs x, y, z, i and atan and outputs nx, ny, nz.

Verification
REQ-033 SHALL check x=0x080000, y=0 -> angle 0 ±64 LSB; magnitude 0x0D2C9E ±64 LSB, or 0x080000 ±64 LSB with the gain macro; done high exactly 17/18 edges after start.
REQ-034 SHALL check x=y=0x080000 -> angle 0x0C90FE ±64 LSB.
REQ-035 SHALL check x=-0x080000, y=0 -> angle 0x3243F6 ±64 LSB; and x=0, y=-0x080000 -> angle -0x1921FB ±64 LSB.
REQ-036 SHALL check start at iteration 7 with new operands -> old result discarded; done asserted 17/18 edges after the second start with the new result.
REQ-037 SHALL check aclr_n pulsed low mid-ITER -> done=0, angle=magnitude=0 immediately, no done pulse until the next start.
REQ-038 SHALL check clk_en low for 5 cycles mid-ITER -> done is delayed exactly 5 cycles and the result is bit-identical to an unstalled run.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the CORDIC vectoring block.
// CORDIC_VEC_GAIN_EN adds the GAIN state and lengthens the latency by one edge.
package cordic_pkg;

  localparam logic [19:0] K    = 20'h9B74E;
  localparam int          PI_2 = 32'h001921FB;
  localparam int          PI   = 32'h003243F6;

`ifdef CORDIC_VEC_GAIN_EN
  localparam int LATENCY = 32'd18;
`else
  localparam int LATENCY = 32'd17;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREROT = 3'd1,
    S_ITER   = 3'd2,
`ifdef CORDIC_VEC_GAIN_EN
    S_GAIN   = 3'd4,
`endif
    S_DONE   = 3'd3
  } state_t;

  // atan(2^-i) in Q.20 radians
  function automatic logic [19:0] atan_lut(input logic [3:0] idx);
    logic [19:0] v;
    case (idx)
      4'd0:    v = 20'hC90FE;
      4'd1:    v = 20'h76B19;
      4'd2:    v = 20'h3EB6F;
      4'd3:    v = 20'h1FD5C;
      4'd4:    v = 20'h0FFAB;
      4'd5:    v = 20'h07FF5;
      4'd6:    v = 20'h03FFF;
      4'd7:    v = 20'h02000;
      4'd8:    v = 20'h01000;
      4'd9:    v = 20'h00800;
      4'd10:   v = 20'h00400;
      4'd11:   v = 20'h00200;
      4'd12:   v = 20'h00100;
      4'd13:   v = 20'h00080;
      4'd14:   v = 20'h00040;
      4'd15:   v = 20'h00020;
      default: v = 20'h00000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational CORDIC vectoring micro-rotation: drives y toward zero.
module cordic_vec_step #(
  parameter int W = 23
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] z,
  input  logic        [3:0]   i,
  input  logic signed [W-1:0] atan,
  output logic signed [W-1:0] nx,
  output logic signed [W-1:0] ny,
  output logic signed [W-1:0] nz
);

  logic signed [W-1:0] xs_s;
  logic signed [W-1:0] ys_s;

  assign xs_s = x >>> i;
  assign ys_s = y >>> i;

  // Rotation direction chosen by the sign of y; all terms use pre-update values
  always_comb begin
    nx = x;
    ny = y;
    nz = z;
    if (!y[W-1]) begin
      nx = x + ys_s;
      ny = y - xs_s;
      nz = z + atan;
    end else begin
      nx = x - ys_s;
      ny = y + xs_s;
      nz = z - atan;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring: angle = atan2(y_in, x_in), magnitude = |(x_in, y_in)|.
// Define CORDIC_VEC_GAIN_EN to add a GAIN state that removes the CORDIC gain from magnitude.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int ITER  = 16,
  parameter int W_IN  = 21,
  parameter int W_OUT = 23
) (
  input  logic                    clock,
  input  logic                    aclr_n,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic signed [W_IN-1:0]  x_in,
  input  logic signed [W_IN-1:0]  y_in,
  output logic signed [W_OUT-1:0] angle,
  output logic signed [W_OUT-1:0] magnitude,
  output logic                    done
);

  state_t                  state_r;
  logic [3:0]              idx_r;
  logic signed [W_OUT-1:0] x_r;
  logic signed [W_OUT-1:0] y_r;
  logic signed [W_OUT-1:0] z_r;
  logic                    zero_r;
  logic                    done_r;
  logic signed [W_OUT-1:0] atan_s;
  logic signed [W_OUT-1:0] nx_s;
  logic signed [W_OUT-1:0] ny_s;
  logic signed [W_OUT-1:0] nz_s;

  assign atan_s = W_OUT'(atan_lut(idx_r));

  cordic_vec_step #(.W(W_OUT)) u_step (
    .x    (x_r),
    .y    (y_r),
    .z    (z_r),
    .i    (idx_r),
    .atan (atan_s),
    .nx   (nx_s),
    .ny   (ny_s),
    .nz   (nz_s)
  );

`ifdef CORDIC_VEC_GAIN_EN
  localparam logic signed [W_OUT-1:0] K_S = W_OUT'(K);
  logic signed [2*W_OUT-1:0] prod_s;
  assign prod_s = (2*W_OUT)'(x_r) * (2*W_OUT)'(K_S);
`endif

  // Conversion sequencer: capture, quadrant pre-rotate, iterate, optional gain, hold
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_r <= S_IDLE;
      idx_r   <= 4'd0;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      zero_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (clk_en) begin
      if (start) begin
        state_r <= S_PREROT;
        idx_r   <= 4'd0;
        x_r     <= W_OUT'(x_in);
        y_r     <= W_OUT'(y_in);
        z_r     <= '0;
        zero_r  <= 1'b0;
        done_r  <= 1'b0;
      end else begin
        case (state_r)
          S_PREROT: begin
            // A zero vector would otherwise accumulate every atan step into z
            zero_r  <= (x_r == '0) && (y_r == '0);
            idx_r   <= 4'd0;
            state_r <= S_ITER;
            if (!x_r[W_OUT-1]) begin
              z_r <= '0;
            end else if (!y_r[W_OUT-1]) begin
              x_r <= y_r;
              y_r <= -x_r;
              z_r <= W_OUT'(PI_2);
            end else begin
              x_r <= -y_r;
              y_r <= x_r;
              z_r <= -(W_OUT'(PI_2));
            end
          end
          S_ITER: begin
            x_r <= nx_s;
            y_r <= ny_s;
            z_r <= zero_r ? '0 : nz_s;
            if (idx_r == 4'(ITER - 1)) begin
              idx_r <= 4'd0;
`ifdef CORDIC_VEC_GAIN_EN
              state_r <= S_GAIN;
`else
              state_r <= S_DONE;
              done_r  <= 1'b1;
`endif
            end else begin
              idx_r <= idx_r + 4'd1;
            end
          end
`ifdef CORDIC_VEC_GAIN_EN
          S_GAIN: begin
            x_r     <= W_OUT'(prod_s >>> 20);
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end
`endif
          S_DONE:  state_r <= S_DONE;
          S_IDLE:  state_r <= S_IDLE;
          default: begin
            state_r <= S_IDLE;
            done_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign angle     = z_r;
  assign magnitude = x_r;
  assign done      = done_r;

endmodule
